// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, segment patterns and FSM state type for the BCD display
package seg_pkg;

    // Active-low patterns written MSB = seg a ... LSB = seg g
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [6:0] SEG_DASH  = 7'b111_1110;

    localparam logic [6:0] SEG_D0 = 7'b000_0001;
    localparam logic [6:0] SEG_D1 = 7'b100_1111;
    localparam logic [6:0] SEG_D2 = 7'b001_0010;
    localparam logic [6:0] SEG_D3 = 7'b000_0110;
    localparam logic [6:0] SEG_D4 = 7'b100_1100;
    localparam logic [6:0] SEG_D5 = 7'b010_0100;
    localparam logic [6:0] SEG_D6 = 7'b010_0000;
    localparam logic [6:0] SEG_D7 = 7'b000_1111;
    localparam logic [6:0] SEG_D8 = 7'b000_0000;
    localparam logic [6:0] SEG_D9 = 7'b000_0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Decimal digits needed for bin_w bits, plus one spare: ceil(bin_w*log10(2)) + 1
    function automatic int nd_int(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000 + 1;
    endfunction

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_D0;
            4'd1:    return SEG_D1;
            4'd2:    return SEG_D2;
            4'd3:    return SEG_D3;
            4'd4:    return SEG_D4;
            4'd5:    return SEG_D5;
            4'd6:    return SEG_D6;
            4'd7:    return SEG_D7;
            4'd8:    return SEG_D8;
            4'd9:    return SEG_D9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// rtl/seg7_digit_dec.sv - one BCD digit to active-low 7-segment pattern with blank and dash overrides
module seg7_digit_dec
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    // Dash outranks blank so an overflowed display never shows empty digits
    always_comb begin
        seg = digit_pattern(digit);
        if (blank) seg = SEG_BLANK;
        if (dash)  seg = SEG_DASH;
    end

endmodule

// File: rtl/seg_disp_bcd.sv
// rtl/seg_disp_bcd.sv - sequential binary-to-BCD converter driving NUM_DIGITS 7-segment displays
module seg_disp_bcd
    import seg_pkg::*;
#(
    parameter int BIN_W      = 7,
    parameter int NUM_DIGITS = 7,
    parameter int BLINK_DIV  = 24
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic [BIN_W-1:0]        bin_in,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int ND_INT = nd_int(BIN_W);
    localparam int ACC_W  = 4 * ND_INT;
    localparam int PAD_D  = (ND_INT > NUM_DIGITS) ? ND_INT : NUM_DIGITS;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    state_t                  state, state_nxt;
    logic [BIN_W-1:0]        bin_sr;
    logic [ACC_W-1:0]        acc, acc_adj;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    last_bit;
    logic [BLINK_DIV-1:0]    blink_cnt;
    logic                    blink_phase;
    logic [4*PAD_D-1:0]      acc_pad;
    logic [4*NUM_DIGITS-1:0] bcd_nxt;
    logic                    ovf_nxt;
    logic [NUM_DIGITS-1:0]   dig_blank;
    logic                    lz_seen;
    logic [7*NUM_DIGITS-1:0] seg_nxt, seg_reg;

    assign last_bit    = (bit_cnt == CNT_W'(BIN_W - 1));
    assign busy        = (state != IDLE);
    assign blink_phase = blink_cnt[BLINK_DIV-1];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied before every shift keeps each nibble decimal
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < ND_INT; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bin_sr  <= '0;
            acc     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr  <= bin_in;
                        acc     <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    {acc, bin_sr} <= {acc_adj, bin_sr} << 1;
                    bit_cnt       <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pad the accumulator so narrow converters still fill every display digit
    always_comb begin
        acc_pad            = '0;
        acc_pad[ACC_W-1:0] = acc;
        bcd_nxt            = acc_pad[4*NUM_DIGITS-1:0];
        ovf_nxt            = 1'b0;
        for (int i = NUM_DIGITS; i < PAD_D; i++) begin
            if (acc_pad[4*i +: 4] != 4'd0) ovf_nxt = 1'b1;
        end
    end

    // Walk down from the top digit; everything above the first non-zero is blanked
    always_comb begin
        lz_seen   = 1'b0;
        dig_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_seen      = lz_seen | (bcd_nxt[4*k +: 4] != 4'd0);
            dig_blank[k] = lz_blank && !lz_seen && (k != 0);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
            seg_reg  <= '1;
        end else begin
            done <= (state == UPDATE);
            if (state == UPDATE) begin
                bcd_out  <= bcd_nxt;
                overflow <= ovf_nxt;
                seg_reg  <= seg_nxt;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) blink_cnt <= '0;
        else         blink_cnt <= blink_cnt + 1'b1;
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        seg7_digit_dec u_dec (
            .digit (bcd_nxt[4*k +: 4]),
            .blank (dig_blank[k]),
            .dash  (ovf_nxt),
            .seg   (seg_nxt[7*k +: 7])
        );

        // Blink sits after the register so blink_en acts in the same cycle
        assign hex_out[7*k +: 7] = (blink_en[k] && blink_phase) ? SEG_BLANK : seg_reg[7*k +: 7];
    end

endmodule

// File: tb/tb_seg_disp_bcd.sv
// tb/tb_seg_disp_bcd.sv - directed self-checking bench for seg_disp_bcd
module tb_seg_disp_bcd;

    localparam logic [6:0] P_BL = 7'b111_1111;
    localparam logic [6:0] P_DS = 7'b111_1110;
    localparam logic [6:0] P0   = 7'b000_0001;
    localparam logic [6:0] P1   = 7'b100_1111;
    localparam logic [6:0] P2   = 7'b001_0010;
    localparam logic [6:0] P4   = 7'b100_1100;
    localparam logic [6:0] P5   = 7'b010_0100;
    localparam logic [6:0] P7   = 7'b000_1111;
    localparam logic [6:0] P9   = 7'b000_0100;

    logic        clk = 1'b0;
    logic        resetn;

    logic [6:0]  a_bin;
    logic        a_load, a_lz;
    logic [6:0]  a_blink;
    logic        a_busy, a_done, a_ovf;
    logic [27:0] a_bcd;
    logic [48:0] a_hex;

    logic [15:0] b_bin;
    logic        b_load, b_lz;
    logic [3:0]  b_blink;
    logic        b_busy, b_done, b_ovf;
    logic [15:0] b_bcd;
    logic [27:0] b_hex;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seg_disp_bcd #(.BIN_W(7), .NUM_DIGITS(7), .BLINK_DIV(4)) dut_a (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bin_in   (a_bin),
        .load     (a_load),
        .lz_blank (a_lz),
        .blink_en (a_blink),
        .busy     (a_busy),
        .done     (a_done),
        .overflow (a_ovf),
        .bcd_out  (a_bcd),
        .hex_out  (a_hex)
    );

    seg_disp_bcd #(.BIN_W(16), .NUM_DIGITS(4), .BLINK_DIV(24)) dut_b (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bin_in   (b_bin),
        .load     (b_load),
        .lz_blank (b_lz),
        .blink_en (b_blink),
        .busy     (b_busy),
        .done     (b_done),
        .overflow (b_ovf),
        .bcd_out  (b_bcd),
        .hex_out  (b_hex)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input logic [6:0] v, input logic lz, output int edges);
        a_bin  = v;
        a_lz   = lz;
        a_load = 1'b1;
        tick();
        a_load = 1'b0;
        edges  = 0;
        while (!a_done && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_b(input logic [15:0] v, output int edges);
        b_bin  = v;
        b_load = 1'b1;
        tick();
        b_load = 1'b0;
        edges  = 0;
        while (!b_done && edges < 60) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        int          n;
        int          ndone;
        int          berr;
        int          derr;
        logic [6:0]  first;
        logic [6:0]  v0;
        logic [6:0]  other;
        logic [6:0]  expd;

        resetn  = 1'b0;
        a_bin   = '0; a_load = 1'b0; a_lz = 1'b1; a_blink = '0;
        b_bin   = '0; b_load = 1'b0; b_lz = 1'b1; b_blink = '0;

        #12;
        check("reset_hex",  a_hex,  {49{1'b1}});
        check("reset_busy", a_busy, 1'b0);
        check("reset_done", a_done, 1'b0);
        check("reset_ovf",  a_ovf,  1'b0);
        check("reset_bcd",  a_bcd,  28'h0);
        resetn = 1'b1;
        tick();

        // 127 with leading-zero blanking
        run_a(7'd127, 1'b1, n);
        check("lat127_edges", n, 8);
        check("lat127_busy",  a_busy, 1'b0);
        check("val127_bcd",   a_bcd, 28'h0000127);
        check("val127_hex",   a_hex, {28'hFFFFFFF, P1, P2, P7});
        tick();
        check("done_one_cycle", a_done, 1'b0);

        run_a(7'd0, 1'b1, n);
        check("zero_lz1_hex", a_hex, {42'h3FF_FFFF_FFFF, P0});
        run_a(7'd0, 1'b0, n);
        check("zero_lz0_hex", a_hex, {P0, P0, P0, P0, P0, P0, P0});

        // Load collision: the second request lands while busy
        a_bin = 7'd127; a_lz = 1'b1; a_load = 1'b1;
        tick();
        a_load = 1'b0;
        check("busy_after_load", a_busy, 1'b1);
        tick();
        tick();
        a_bin = 7'd5; a_load = 1'b1;
        tick();
        a_load = 1'b0;
        n = 0;
        while (!a_done && n < 40) begin
            tick();
            n++;
        end
        check("coll_done_seen", (n < 40), 1'b1);
        check("coll_bcd", a_bcd, 28'h0000127);
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (a_done) ndone++;
        end
        check("coll_no_second_done", ndone, 0);
        check("coll_hex_held", a_hex, {28'hFFFFFFF, P1, P2, P7});

        run_a(7'd5, 1'b1, n);
        check("load5_bcd", a_bcd, 28'h0000005);
        check("load5_hex", a_hex, {42'h3FF_FFFF_FFFF, P5});

        // Reset in the middle of a conversion
        a_bin = 7'd42; a_load = 1'b1;
        tick();
        a_load = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check("midrst_hex",  a_hex,  {49{1'b1}});
        check("midrst_busy", a_busy, 1'b0);
        check("midrst_done", a_done, 1'b0);
        check("midrst_bcd",  a_bcd,  28'h0);
        tick();
        resetn = 1'b1;
        tick();

        // Blink on digit 0 of 42: digit 0 is "2", digit 1 is "4"
        run_a(7'd42, 1'b1, n);
        check("val42_hex", a_hex, {35'h7_FFFF_FFFF, P4, P2});
        a_blink = 7'b000_0001;
        #1;
        first = a_hex[6:0];
        n = 0;
        while (a_hex[6:0] === first && n < 20) begin
            tick();
            n++;
        end
        check("blink_toggle_seen", (n < 20), 1'b1);
        v0 = a_hex[6:0];
        other = (v0 === P_BL) ? P2 : P_BL;
        check("blink_value_legal", ((v0 === P_BL) || (v0 === P2)), 1'b1);
        berr = 0;
        derr = 0;
        for (int i = 0; i < 24; i++) begin
            expd = (((i / 8) % 2) == 0) ? v0 : other;
            if (a_hex[6:0] !== expd) berr++;
            if (a_hex[13:7] !== P4)  derr++;
            tick();
        end
        check("blink_period8",       berr, 0);
        check("blink_digit1_steady", derr, 0);

        n = 0;
        while (a_hex[6:0] !== P_BL && n < 20) begin
            tick();
            n++;
        end
        check("blink_blank_phase_seen", (n < 20), 1'b1);
        a_blink = 7'b000_0000;
        #1;
        check("blink_off_same_cycle", a_hex[6:0], P2);
        a_blink = 7'b000_0001;
        #1;
        check("blink_on_same_cycle", a_hex[6:0], P_BL);
        a_blink = '0;

        // Wide converter feeding only four digits
        run_b(16'd65535, n);
        check("b_lat_edges", n, 17);
        check("b_ovf_65535", b_ovf, 1'b1);
        check("b_hex_65535", b_hex, {P_DS, P_DS, P_DS, P_DS});
        check("b_bcd_65535", b_bcd, 16'h5535);
        run_b(16'd9999, n);
        check("b_ovf_9999", b_ovf, 1'b0);
        check("b_hex_9999", b_hex, {P9, P9, P9, P9});
        check("b_bcd_9999", b_bcd, 16'h9999);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
